// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_mux
//  Description : CH:1 data multiplexer with a valid/ready handshake on every
//                input and on the output. The channel is picked either by
//                round-robin arbitration (mode=0) or by an external index
//                (mode=1). The selected word goes into one output register,
//                which can take a new word every cycle.
//  Ports       :
//    clk        in   1         rising-edge clock
//    rst_n      in   1         asynchronous reset, active-low
//    mode       in   1         0 = round-robin, 1 = fixed select
//    sel        in   SELW      channel index used when mode=1
//    in_valid   in   CH        per-channel request
//    in_data    in   CH*N      channel i data at [i*N +: N]
//    in_ready   out  CH        per-channel accept (one-hot or zero)
//    out_valid  out  1         output register holds a valid word
//    out_data   out  N         registered data
//    out_sel    out  SELW      channel that supplied out_data
//    out_ready  in   1         downstream accept
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb_mux #(
    parameter  int N    = 32,
    parameter  int CH   = 16,
    localparam int SELW = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [CH-1:0]     in_valid,
    input  logic [CH*N-1:0]   in_data,
    output logic [CH-1:0]     in_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    input  logic              out_ready
);

    localparam logic [SELW-1:0] C_LAST = SELW'(CH - 1);

    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_grant;
    logic            w_grant_valid;
    logic            w_load;

    // The output register may take a word when it is empty or being drained
    // in this same cycle, so back-to-back transfers incur no bubble.
    assign w_load = !out_valid || out_ready;

    // Grant selection. Round-robin walks ptr, ptr+1, ... wrapping at CH-1;
    // the first requesting channel wins. Fixed mode only honours an
    // in-range sel whose channel is requesting.
    always_comb begin : p_grant
        int  idx;
        logic found;
        w_grant       = '0;
        w_grant_valid = 1'b0;
        found         = 1'b0;
        idx           = 0;
        if (mode) begin
            if ((int'(sel) < CH) && in_valid[sel]) begin
                w_grant       = sel;
                w_grant_valid = 1'b1;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= CH) begin
                    idx = idx - CH;
                end
                if (!found && in_valid[idx]) begin
                    found   = 1'b1;
                    w_grant = SELW'(idx);
                end
            end
            w_grant_valid = found;
        end
    end

    // Only the granted channel sees ready, and never during reset.
    always_comb begin : p_ready
        in_ready = '0;
        if (w_load && w_grant_valid && rst_n) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_out
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            if (w_grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(w_grant)*N +: N];
                out_sel   <= w_grant;
                // Pointer moves past the winner so it has lowest priority
                // next time; fixed-mode transfers leave it alone.
                if (!mode) begin
                    r_ptr <= (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
